// File: rtl/thumb_dec_pkg.sv
// Shared types for the Thumb decode stage: op classes, decoded-field payload,
// BL/BLX opcode constants and the single-halfword decoder.
package thumb_dec_pkg;

  localparam int unsigned CLS_W = 5;

  localparam logic [3:0] REG_SP = 4'd13;
  localparam logic [3:0] REG_LR = 4'd14;
  localparam logic [3:0] REG_PC = 4'd15;

  localparam logic [4:0] OP_BL_PREFIX  = 5'b11110;
  localparam logic [4:0] OP_BL_SUFFIX  = 5'b11111;
  localparam logic [4:0] OP_BLX_SUFFIX = 5'b11101;

  typedef enum logic [CLS_W-1:0] {
    CLS_SHIFT_IMM = 5'd0,
    CLS_ALU_3OP   = 5'd1,
    CLS_ALU_IMM8  = 5'd2,
    CLS_ALU_REG   = 5'd3,
    CLS_HI_REG    = 5'd4,
    CLS_BX        = 5'd5,
    CLS_LDR_PC    = 5'd6,
    CLS_LDST_REG  = 5'd7,
    CLS_LDST_IMM  = 5'd8,
    CLS_LDST_SP   = 5'd9,
    CLS_ADR       = 5'd10,
    CLS_SP_ADJ    = 5'd11,
    CLS_PUSH_POP  = 5'd12,
    CLS_LDM_STM   = 5'd13,
    CLS_BCOND     = 5'd14,
    CLS_B         = 5'd15,
    CLS_BL        = 5'd16,
    CLS_SWI       = 5'd17,
    CLS_BKPT      = 5'd18,
    CLS_UNDEF     = 5'd19,
    CLS_BLX       = 5'd20
  } op_class_e;

  typedef struct packed {
    op_class_e   cls;
    logic [3:0]  rd;
    logic [3:0]  rn;
    logic [3:0]  rm;
    logic [31:0] imm;
    logic        len32;
    logic        undef;
  } dec_fields_t;

  // Classify one 16-bit halfword; BL/BLX halves decode as UNDEF here and are
  // paired by the stage itself.
  function automatic dec_fields_t decode16(input logic [15:0] hw);
    dec_fields_t f;
    f     = '0;
    f.cls = CLS_UNDEF;
    casez (hw[15:11])
      5'b00011: begin
        f.cls = CLS_ALU_3OP;
        f.rd  = {1'b0, hw[2:0]};
        f.rn  = {1'b0, hw[5:3]};
        if (hw[10]) f.imm = 32'(hw[8:6]);
        else        f.rm  = {1'b0, hw[8:6]};
      end
      5'b000??: begin
        f.cls = CLS_SHIFT_IMM;
        f.rd  = {1'b0, hw[2:0]};
        f.rm  = {1'b0, hw[5:3]};
        f.imm = 32'(hw[10:6]);
      end
      5'b001??: begin
        f.cls = CLS_ALU_IMM8;
        f.rd  = {1'b0, hw[10:8]};
        f.rn  = {1'b0, hw[10:8]};
        f.imm = 32'(hw[7:0]);
      end
      5'b01000: begin
        if (!hw[10]) begin
          f.cls = CLS_ALU_REG;
          f.rd  = {1'b0, hw[2:0]};
          f.rn  = {1'b0, hw[2:0]};
          f.rm  = {1'b0, hw[5:3]};
        end else if (hw[9:8] == 2'b11) begin
          f.cls = CLS_BX;
          f.rm  = hw[6:3];
        end else begin
          f.cls = CLS_HI_REG;
          f.rd  = {hw[7], hw[2:0]};
          f.rn  = {hw[7], hw[2:0]};
          f.rm  = hw[6:3];
        end
      end
      5'b01001: begin
        f.cls = CLS_LDR_PC;
        f.rd  = {1'b0, hw[10:8]};
        f.rn  = REG_PC;
        f.imm = 32'({hw[7:0], 2'b00});
      end
      5'b0101?: begin
        f.cls = CLS_LDST_REG;
        f.rd  = {1'b0, hw[2:0]};
        f.rn  = {1'b0, hw[5:3]};
        f.rm  = {1'b0, hw[8:6]};
      end
      5'b011??: begin
        // bit 12 selects byte (unscaled) versus word (x4) offset
        f.cls = CLS_LDST_IMM;
        f.rd  = {1'b0, hw[2:0]};
        f.rn  = {1'b0, hw[5:3]};
        f.imm = hw[12] ? 32'(hw[10:6]) : 32'({hw[10:6], 2'b00});
      end
      5'b1000?: begin
        f.cls = CLS_LDST_IMM;
        f.rd  = {1'b0, hw[2:0]};
        f.rn  = {1'b0, hw[5:3]};
        f.imm = 32'({hw[10:6], 1'b0});
      end
      5'b1001?: begin
        f.cls = CLS_LDST_SP;
        f.rd  = {1'b0, hw[10:8]};
        f.rn  = REG_SP;
        f.imm = 32'({hw[7:0], 2'b00});
      end
      5'b1010?: begin
        f.cls = CLS_ADR;
        f.rd  = {1'b0, hw[10:8]};
        f.rn  = hw[11] ? REG_SP : REG_PC;
        f.imm = 32'({hw[7:0], 2'b00});
      end
      5'b1011?: begin
        case (hw[11:8])
          4'b0000: begin
            f.cls = CLS_SP_ADJ;
            f.rd  = REG_SP;
            f.rn  = REG_SP;
            f.imm = 32'({hw[6:0], 2'b00});
          end
          4'b0100, 4'b0101, 4'b1100, 4'b1101: begin
            // R bit adds LR to a push or PC to a pop
            f.cls = CLS_PUSH_POP;
            f.rn  = REG_SP;
            f.imm = 32'({hw[11] & hw[8], ~hw[11] & hw[8], 6'b000000, hw[7:0]});
          end
          4'b1110: begin
            f.cls = CLS_BKPT;
            f.imm = 32'(hw[7:0]);
          end
          default: ;
        endcase
      end
      5'b1100?: begin
        f.cls = CLS_LDM_STM;
        f.rn  = {1'b0, hw[10:8]};
        f.imm = 32'(hw[7:0]);
      end
      5'b1101?: begin
        if (hw[11:8] == 4'b1111) begin
          f.cls = CLS_SWI;
          f.imm = 32'(hw[7:0]);
        end else if (hw[11:8] != 4'b1110) begin
          f.cls = CLS_BCOND;
          f.rd  = hw[11:8];
          f.imm = {{23{hw[7]}}, hw[7:0], 1'b0};
        end
      end
      5'b11100: begin
        f.cls = CLS_B;
        f.imm = {{20{hw[10]}}, hw[10:0], 1'b0};
      end
      default: ;
    endcase
    f.undef = (f.cls == CLS_UNDEF);
    return f;
  endfunction

endpackage

// File: rtl/thumb_hw_fifo.sv
// Halfword + PC prefetch buffer: one push, pop of 0/1/2, head and head+1
// exposed, synchronous flush, registered ready.
module thumb_hw_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [15:0]      push_hw,
  input  logic [PC_W-1:0]  push_pc,
  input  logic [1:0]       pop,
  output logic [15:0]      head_hw,
  output logic [PC_W-1:0]  head_pc,
  output logic [15:0]      next_hw,
  output logic [PC_W-1:0]  next_pc,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [15:0]      mem_hw [DEPTH];
  logic [PC_W-1:0]  mem_pc [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_nx;
  logic [CNT_W-1:0] count_q, count_next_c;
  logic             ready_q;
  logic             push_c;

  assign push_c    = push_valid && ready_q && !flush;
  assign rd_ptr_nx = rd_ptr + AW'(1);

  always_comb begin
    count_next_c = count_q + CNT_W'(push_c) - CNT_W'(pop);
    if (flush) count_next_c = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
    end else begin
      count_q <= count_next_c;
      ready_q <= (count_next_c < CNT_W'(DEPTH));
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_c) wr_ptr <= wr_ptr + AW'(1);
        rd_ptr <= rd_ptr + AW'(pop);
      end
    end
  end

  // Storage carries no reset; count qualifies every read.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_hw[wr_ptr] <= push_hw;
      mem_pc[wr_ptr] <= push_pc;
    end
  end

  assign push_ready = ready_q;
  assign count      = count_q;
  assign head_hw    = mem_hw[rd_ptr];
  assign head_pc    = mem_pc[rd_ptr];
  assign next_hw    = mem_hw[rd_ptr_nx];
  assign next_pc    = mem_pc[rd_ptr_nx];

endmodule

// File: rtl/thumb_decode_stage.sv
// Thumb decode stage: prefetch buffer, BL pair fusion, registered micro-op out.
// Optional: define THUMB_BLX_SUFFIX_EN to fuse prefix + 11101 suffix into BLX.
module thumb_decode_stage #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PC_W       = 32,
  parameter int unsigned CLS_W      = thumb_dec_pkg::CLS_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             hw_valid,
  output logic             hw_ready,
  input  logic [15:0]      hw_data,
  input  logic [PC_W-1:0]  hw_pc,
  output logic             dec_valid,
  input  logic             dec_ready,
  output logic [CLS_W-1:0] dec_class,
  output logic [3:0]       dec_rd,
  output logic [3:0]       dec_rn,
  output logic [3:0]       dec_rm,
  output logic [31:0]      dec_imm,
  output logic [PC_W-1:0]  dec_pc,
  output logic             dec_len32,
  output logic             dec_undef
);
  import thumb_dec_pkg::*;

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [15:0]      head_hw, next_hw;
  logic [PC_W-1:0]  head_pc, next_pc;
  logic [CNT_W-1:0] count;
  logic [1:0]       pop_c;
  logic [1:0]       op_len_c;
  logic             have_op_c, load_c, pair_c;
  dec_fields_t      op_c;
  dec_fields_t      out_q;
  logic [PC_W-1:0]  out_pc_q;
  logic             out_valid_q;

  thumb_hw_fifo #(
    .DEPTH (FIFO_DEPTH),
    .PC_W  (PC_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push_valid (hw_valid),
    .push_ready (hw_ready),
    .push_hw    (hw_data),
    .push_pc    (hw_pc),
    .pop        (pop_c),
    .head_hw    (head_hw),
    .head_pc    (head_pc),
    .next_hw    (next_hw),
    .next_pc    (next_pc),
    .count      (count)
  );

  assign pair_c = (next_pc == head_pc + PC_W'(2));

  // Decode the head; a prefix waits for its partner before anything issues.
  always_comb begin
    op_c      = decode16(head_hw);
    have_op_c = (count != '0);
    op_len_c  = 2'd1;
    if (head_hw[15:11] == OP_BL_PREFIX) begin
      if (count < CNT_W'(2)) begin
        have_op_c = 1'b0;
      end else if (pair_c && next_hw[15:11] == OP_BL_SUFFIX) begin
        op_c       = '0;
        op_c.cls   = CLS_BL;
        op_c.rd    = REG_LR;
        op_c.imm   = {{9{head_hw[10]}}, head_hw[10:0], next_hw[10:0], 1'b0};
        op_c.len32 = 1'b1;
        op_len_c   = 2'd2;
      end
`ifdef THUMB_BLX_SUFFIX_EN
      else if (pair_c && next_hw[15:11] == OP_BLX_SUFFIX) begin
        op_c       = '0;
        op_c.cls   = CLS_BLX;
        op_c.rd    = REG_LR;
        op_c.imm   = {{9{head_hw[10]}}, head_hw[10:0], next_hw[10:1], 2'b00};
        op_c.len32 = 1'b1;
        op_len_c   = 2'd2;
      end
`endif
    end
    load_c = !flush && (!out_valid_q || dec_ready);
    pop_c  = (load_c && have_op_c) ? op_len_c : 2'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_pc_q    <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (load_c) begin
      out_valid_q <= have_op_c;
      if (have_op_c) begin
        out_q    <= op_c;
        out_pc_q <= head_pc;
      end
    end
  end

  assign dec_valid = out_valid_q;
  assign dec_class = CLS_W'(out_q.cls);
  assign dec_rd    = out_q.rd;
  assign dec_rn    = out_q.rn;
  assign dec_rm    = out_q.rm;
  assign dec_imm   = out_q.imm;
  assign dec_pc    = out_pc_q;
  assign dec_len32 = out_q.len32;
  assign dec_undef = out_q.undef;

endmodule

// File: tb/tb_thumb_decode_stage.sv
// Scoreboard bench for thumb_decode_stage: directed halfwords in, expected ops
// queued, a negedge monitor pops and compares on every dec_valid && dec_ready.
module tb_thumb_decode_stage;
  import thumb_dec_pkg::*;

  typedef struct packed {
    logic [4:0]  cls;
    logic [3:0]  rd;
    logic [3:0]  rn;
    logic [3:0]  rm;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        len32;
    logic        undef;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        hw_valid = 1'b0;
  logic        hw_ready;
  logic [15:0] hw_data = '0;
  logic [31:0] hw_pc = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b1;
  logic [4:0]  dec_class;
  logic [3:0]  dec_rd, dec_rn, dec_rm;
  logic [31:0] dec_imm, dec_pc;
  logic        dec_len32, dec_undef;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];

  thumb_decode_stage #(.FIFO_DEPTH(4), .PC_W(32), .CLS_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .hw_valid(hw_valid), .hw_ready(hw_ready), .hw_data(hw_data), .hw_pc(hw_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_class(dec_class),
    .dec_rd(dec_rd), .dec_rn(dec_rn), .dec_rm(dec_rm), .dec_imm(dec_imm),
    .dec_pc(dec_pc), .dec_len32(dec_len32), .dec_undef(dec_undef)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input op_class_e c, input logic [3:0] rd, rn, rm,
                              input logic [31:0] imm, pc, input logic l, u);
    exp_t e;
    e.cls = 5'(c); e.rd = rd; e.rn = rn; e.rm = rm;
    e.imm = imm; e.pc = pc; e.len32 = l; e.undef = u;
    return e;
  endfunction

  function automatic exp_t cur_out();
    exp_t e;
    e.cls = dec_class; e.rd = dec_rd; e.rn = dec_rn; e.rm = dec_rm;
    e.imm = dec_imm; e.pc = dec_pc; e.len32 = dec_len32; e.undef = dec_undef;
    return e;
  endfunction

  function automatic exp_t und(input logic [31:0] pc);
    return mk(CLS_UNDEF, 4'd0, 4'd0, 4'd0, 32'd0, pc, 1'b0, 1'b1);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: scoreboard pop on transfer, and stability while stalled.
  exp_t prev_out;
  logic prev_stall = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        checks++;
        if (!dec_valid || cur_out() !== prev_out) begin
          errors++;
          $display("FAIL hold: got valid=%0b op=%0h expected valid=1 op=%0h",
                   dec_valid, cur_out(), prev_out);
        end
      end
      if (dec_valid && dec_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_op: got cls=%0d pc=%0h expected no op", dec_class, dec_pc);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (cur_out() !== e) begin
            errors++;
            $display("FAIL op@%0h: got cls=%0d rd=%0d rn=%0d rm=%0d imm=%0h pc=%0h l=%0b u=%0b expected cls=%0d rd=%0d rn=%0d rm=%0d imm=%0h pc=%0h l=%0b u=%0b",
                     e.pc, dec_class, dec_rd, dec_rn, dec_rm, dec_imm, dec_pc, dec_len32, dec_undef,
                     e.cls, e.rd, e.rn, e.rm, e.imm, e.pc, e.len32, e.undef);
          end
        end
      end
      prev_stall = dec_valid && !dec_ready && !flush;
      prev_out   = cur_out();
    end
  end

  task automatic send(input logic [15:0] d, input logic [31:0] p);
    logic r;
    int   n;
    hw_valid = 1'b1; hw_data = d; hw_pc = p; n = 0;
    do begin
      @(negedge clk); r = hw_ready;
      @(posedge clk); #1; n++;
    end while (!r && n < 200);
    if (!r) begin
      checks++; errors++;
      $display("FAIL send_timeout: got hw_ready=0 for 200 cycles expected acceptance of %0h", d);
    end
    hw_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d ops pending expected 0", q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic vec(input logic [15:0] d, input logic [31:0] p, input exp_t e);
    q.push_back(e);
    send(d, p);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] hw;
    // reset state
    repeat (2) @(posedge clk); #1;
    check("rst_valid", 128'(dec_valid), 128'd0);
    check("rst_fields", 128'({dec_class, dec_rd, dec_rn, dec_rm, dec_imm, dec_pc, dec_len32, dec_undef}), 128'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_hw_ready", 128'(hw_ready), 128'd1);

    // single op latency N+2
    q.push_back(mk(CLS_ALU_3OP, 4'd0, 4'd1, 4'd0, 32'd1, 32'h100, 1'b0, 1'b0));
    send(16'h1C48, 32'h100);
    @(negedge clk); check("lat_n1", 128'(dec_valid), 128'd0);
    @(negedge clk); check("lat_n2", 128'(dec_valid), 128'd1);
    drain();

    // BL pair
    q.push_back(mk(CLS_BL, 4'd14, 4'd0, 4'd0, 32'hFFFFFFFC, 32'h200, 1'b1, 1'b0));
    send(16'hF7FF, 32'h200);
    send(16'hFFFE, 32'h202);
    drain();

    // prefix waits for a late suffix
    q.push_back(mk(CLS_BL, 4'd14, 4'd0, 4'd0, 32'd2, 32'h300, 1'b1, 1'b0));
    send(16'hF000, 32'h300);
    repeat (3) begin @(negedge clk); check("prefix_wait", 128'(dec_valid), 128'd0); end
    @(posedge clk); #1;
    send(16'hF801, 32'h302);
    drain();

    // prefix followed by a non-suffix
    q.push_back(und(32'h400));
    q.push_back(mk(CLS_ALU_IMM8, 4'd0, 4'd0, 4'd0, 32'd1, 32'h402, 1'b0, 1'b0));
    send(16'hF000, 32'h400);
    send(16'h2001, 32'h402);
    drain();

    // prefix + 11101 suffix
`ifdef THUMB_BLX_SUFFIX_EN
    q.push_back(mk(CLS_BLX, 4'd14, 4'd0, 4'd0, 32'd0, 32'h500, 1'b1, 1'b0));
`else
    q.push_back(und(32'h500));
    q.push_back(und(32'h502));
`endif
    send(16'hF000, 32'h500);
    send(16'hE801, 32'h502);
    drain();

    // suffix at wrong pc is not paired
    q.push_back(und(32'h800));
    q.push_back(und(32'h900));
    send(16'hF000, 32'h800);
    send(16'hF801, 32'h900);
    drain();

    // streamed single-halfword classes
    vec(16'h0088, 32'h2000, mk(CLS_SHIFT_IMM, 4'd0, 4'd0, 4'd1, 32'd2, 32'h2000, 1'b0, 1'b0));
    vec(16'h4288, 32'h2002, mk(CLS_ALU_REG, 4'd0, 4'd0, 4'd1, 32'd0, 32'h2002, 1'b0, 1'b0));
    vec(16'h4770, 32'h2004, mk(CLS_BX, 4'd0, 4'd0, 4'd14, 32'd0, 32'h2004, 1'b0, 1'b0));
    vec(16'h4611, 32'h2006, mk(CLS_HI_REG, 4'd1, 4'd1, 4'd2, 32'd0, 32'h2006, 1'b0, 1'b0));
    vec(16'h4801, 32'h2008, mk(CLS_LDR_PC, 4'd0, 4'd15, 4'd0, 32'd4, 32'h2008, 1'b0, 1'b0));
    vec(16'h5888, 32'h200A, mk(CLS_LDST_REG, 4'd0, 4'd1, 4'd2, 32'd0, 32'h200A, 1'b0, 1'b0));
    vec(16'h6848, 32'h200C, mk(CLS_LDST_IMM, 4'd0, 4'd1, 4'd0, 32'd4, 32'h200C, 1'b0, 1'b0));
    vec(16'h8848, 32'h200E, mk(CLS_LDST_IMM, 4'd0, 4'd1, 4'd0, 32'd2, 32'h200E, 1'b0, 1'b0));
    vec(16'h9001, 32'h2010, mk(CLS_LDST_SP, 4'd0, 4'd13, 4'd0, 32'd4, 32'h2010, 1'b0, 1'b0));
    vec(16'hA801, 32'h2012, mk(CLS_ADR, 4'd0, 4'd13, 4'd0, 32'd4, 32'h2012, 1'b0, 1'b0));
    vec(16'hB082, 32'h2014, mk(CLS_SP_ADJ, 4'd13, 4'd13, 4'd0, 32'd8, 32'h2014, 1'b0, 1'b0));
    vec(16'hB510, 32'h2016, mk(CLS_PUSH_POP, 4'd0, 4'd13, 4'd0, 32'h4010, 32'h2016, 1'b0, 1'b0));
    vec(16'hBD10, 32'h2018, mk(CLS_PUSH_POP, 4'd0, 4'd13, 4'd0, 32'h8010, 32'h2018, 1'b0, 1'b0));
    vec(16'hC103, 32'h201A, mk(CLS_LDM_STM, 4'd0, 4'd1, 4'd0, 32'd3, 32'h201A, 1'b0, 1'b0));
    vec(16'hD1FE, 32'h201C, mk(CLS_BCOND, 4'd1, 4'd0, 4'd0, 32'hFFFFFFFC, 32'h201C, 1'b0, 1'b0));
    vec(16'hDF05, 32'h201E, mk(CLS_SWI, 4'd0, 4'd0, 4'd0, 32'd5, 32'h201E, 1'b0, 1'b0));
    vec(16'hDE00, 32'h2020, und(32'h2020));
    vec(16'hE7FE, 32'h2022, mk(CLS_B, 4'd0, 4'd0, 4'd0, 32'hFFFFFFFC, 32'h2022, 1'b0, 1'b0));
    vec(16'hBE01, 32'h2024, mk(CLS_BKPT, 4'd0, 4'd0, 4'd0, 32'd1, 32'h2024, 1'b0, 1'b0));
    vec(16'hE800, 32'h2026, und(32'h2026));
    vec(16'hF800, 32'h2028, und(32'h2028));
    drain();

    // backpressure: stall output, overfill the buffer
    for (int i = 0; i < 6; i++)
      q.push_back(mk(CLS_ALU_IMM8, 4'(i), 4'(i), 4'd0, 32'(i + 1), 32'h1000 + 32'(2 * i), 1'b0, 1'b0));
    dec_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          hw = {5'b00100, 3'(i), 8'(i + 1)};
          send(hw, 32'h1000 + 32'(2 * i));
        end
      end
      begin
        repeat (7) @(negedge clk);
        check("full_hw_ready", 128'(hw_ready), 128'd0);
        check("stall_valid", 128'(dec_valid), 128'd1);
        @(posedge clk); #1;
        dec_ready = 1'b1;
      end
    join
    drain();

    // flush drops buffered, held and same-cycle halfwords
    dec_ready = 1'b0;
    send(16'h2001, 32'h600);
    send(16'h2102, 32'h602);
    flush = 1'b1; hw_valid = 1'b1; hw_data = 16'h2203; hw_pc = 32'h604;
    @(posedge clk); #1;
    flush = 1'b0; hw_valid = 1'b0;
    @(negedge clk);
    check("flush_valid", 128'(dec_valid), 128'd0);
    check("flush_hw_ready", 128'(hw_ready), 128'd1);
    @(posedge clk); #1;
    dec_ready = 1'b1;
    q.push_back(mk(CLS_ALU_IMM8, 4'd3, 4'd3, 4'd0, 32'd4, 32'h700, 1'b0, 1'b0));
    send(16'h2304, 32'h700);
    drain();

    // idle: nothing left, nothing extra
    repeat (5) @(negedge clk);
    check("idle_valid_pending", 128'({dec_valid, 16'(q.size())}), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
